// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment scan display.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] ANODE_OFF = 4'hF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_GLYPH[i_nibble];

endmodule

// File: rtl/hex_display_scan.sv
// Four-digit multiplexed hex display of {left_byte, right_byte}.
// New values are staged in a shadow register and promoted only at frame boundaries.
module hex_display_scan
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] left_byte,
  input  logic [7:0] right_byte,
  input  logic       disp_en,
  output logic [3:0] anode,
  output logic [6:0] cathode,
  output logic       frame_tick,
  output logic       pending
);

  localparam int SLOT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);

  logic [SLOT_W-1:0] r_slot_cnt;
  digit_idx_t        r_digit_idx;
  logic [15:0]       r_shadow;
  logic [15:0]       r_active;

  logic       w_slot_last;
  logic       w_boundary;
  logic       w_lit;
  logic [3:0] w_nibble;
  logic [6:0] w_glyph;
  logic [3:0] w_anode_on;

  assign w_slot_last = (r_slot_cnt == SLOT_LAST);
  assign w_boundary  = w_slot_last && (r_digit_idx == 2'd3);
  assign w_lit       = disp_en && (r_slot_cnt >= SLOT_BLANK);

  always_comb begin
    w_nibble = r_active[3:0];
    case (r_digit_idx)
      2'd0: w_nibble = r_active[3:0];
      2'd1: w_nibble = r_active[7:4];
      2'd2: w_nibble = r_active[11:8];
      2'd3: w_nibble = r_active[15:12];
      default: w_nibble = r_active[3:0];
    endcase
  end

  always_comb begin
    w_anode_on = ANODE_OFF;
    w_anode_on[r_digit_idx] = 1'b0;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_last) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_slot_cnt  <= r_slot_cnt + 1'b1;
    end
  end

  // A strobe landing on the boundary bypasses the shadow so it is shown this frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
      r_active <= '0;
      pending  <= 1'b0;
    end else if (w_boundary) begin
      if (load_valid) begin
        r_active <= {left_byte, right_byte};
        pending  <= 1'b0;
      end else if (pending) begin
        r_active <= r_shadow;
        pending  <= 1'b0;
      end
    end else if (load_valid) begin
      r_shadow <= {left_byte, right_byte};
      pending  <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode      <= ANODE_OFF;
      cathode    <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      anode      <= w_lit ? w_anode_on : ANODE_OFF;
      cathode    <= w_lit ? w_glyph : SEG_OFF;
      frame_tick <= w_boundary;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Self-checking bench for hex_display_scan with DIGIT_CYCLES=4, BLANK_CYCLES=1.
module tb_hex_display_scan;

  localparam int DC = 4;
  localparam int BC = 1;
  localparam int FRAME = 4 * DC;

  localparam logic [6:0] TB_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] left_byte = 8'h00;
  logic [7:0] right_byte = 8'h00;
  logic       disp_en = 1'b1;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic       frame_tick;
  logic       pending;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: position within the 16-cycle frame plus displayed/staged values.
  int          m_pos = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_shadow = '0;
  logic        m_pending = 1'b0;

  hex_display_scan #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .left_byte  (left_byte),
    .right_byte (right_byte),
    .disp_en    (disp_en),
    .anode      (anode),
    .cathode    (cathode),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_anode"},   {12'h000, anode},   16'h000F);
    chk({tag, "_cathode"}, {9'h000, cathode},  16'h007F);
    chk({tag, "_tick"},    {15'h0000, frame_tick}, 16'h0000);
    chk({tag, "_pending"}, {15'h0000, pending},    16'h0000);
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_active = '0;
    m_shadow = '0;
    m_pending = 1'b0;
  endtask

  task automatic step(input logic lv, input logic [7:0] lb, input logic [7:0] rb, input logic en);
    int         q;
    int         digit;
    logic       lit;
    logic [3:0] nib;
    logic [3:0] ea;
    logic [6:0] ec;
    logic       et;
    load_valid = lv;
    left_byte  = lb;
    right_byte = rb;
    disp_en    = en;
    @(posedge clock);
    ea = 4'hF;
    ec = 7'h7F;
    et = 1'b0;
    if (reset) begin
      q     = m_pos;
      digit = q / DC;
      lit   = en && ((q % DC) >= BC);
      nib   = m_active[4*digit +: 4];
      if (lit) begin
        ea[digit] = 1'b0;
        ec = TB_GLYPH[nib];
      end
      et = (q == FRAME - 1);
      if (q == FRAME - 1) begin
        if (lv) begin
          m_active  = {lb, rb};
          m_pending = 1'b0;
        end else if (m_pending) begin
          m_active  = m_shadow;
          m_pending = 1'b0;
        end
      end else if (lv) begin
        m_shadow  = {lb, rb};
        m_pending = 1'b1;
      end
      m_pos = (q + 1) % FRAME;
    end
    #1;
    load_valid = 1'b0;
    chk("anode",   {12'h000, anode},       {12'h000, ea});
    chk("cathode", {9'h000, cathode},      {9'h000, ec});
    chk("tick",    {15'h0000, frame_tick}, {15'h0000, et});
    chk("pending", {15'h0000, pending},    {15'h0000, m_pending});
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, en);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < FRAME && m_pos != p; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  initial begin
    // 1: reset then run
    #2 reset = 1'b0;
    #1 chk_reset_outputs("rst_async");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      chk_reset_outputs("rst_hold");
    end
    model_reset();
    reset = 1'b1;
    step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("first_blank_anode", {12'h000, anode}, 16'h000F);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("first_lit_anode",   {12'h000, anode},  16'h000E);
    chk("first_lit_cathode", {9'h000, cathode}, 16'h0040);
    idle(40, 1'b1);

    // 2: single load mid-frame
    run_to(5);
    step(1'b1, 8'hA5, 8'h3C, 1'b1);
    chk("single_pending", {15'h0000, pending}, 16'h0001);
    run_to(0);
    idle(FRAME + 2, 1'b1);

    // 3: two loads in one frame, last one wins
    run_to(2);
    step(1'b1, 8'h11, 8'h22, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 8'hFE, 8'hDC, 1'b1);
    run_to(0);
    idle(2 * FRAME, 1'b1);

    // 4: load on the boundary cycle
    run_to(FRAME - 1);
    step(1'b1, 8'h80, 8'h08, 1'b1);
    chk("boundary_pending", {15'h0000, pending}, 16'h0000);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("boundary_digit0", {9'h000, cathode}, 16'h0000);
    idle(FRAME, 1'b1);

    // 5: display disable
    idle(20, 1'b0);
    idle(2 * FRAME, 1'b1);

    // 6: reset mid-operation with a pending value
    run_to(6);
    step(1'b1, 8'h5A, 8'h69, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    reset = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    model_reset();
    step(1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    reset = 1'b1;
    idle(3 * FRAME, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic lv;
      logic en;
      lv = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 9) != 0);
      step(lv, 8'($urandom), 8'($urandom), en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Downstream display stage of the median-filter design. Latches the raw sample byte and the filtered median byte, then time-multiplexes them as four hex digits onto the board's 4-digit common-anode seven-segment display. Display updates are frame-synchronous, so a digit scan never shows a mix of old and new values.

## Interface
- `DIGIT_CYCLES`, 100000: clock cycles per digit slot. 1 ms at 100 MHz. Legal range is ≥ 2.
- `BLANK_CYCLES`, 2: cycles at the start of each slot with all anodes off, for anti-ghosting. Must be < `DIGIT_CYCLES`.
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `load_valid`, in, 1: single-cycle strobe. Captures `left_byte` and `right_byte`.
- `left_byte`, in, 8: raw memory/data byte, shown on the two left digits.
- `right_byte`, in, 8: median byte, shown on the two right digits.
- `disp_en`, in, 1: 0 forces all anodes off. Scanning continues.
- `anode`, out, 4: active-low digit enables. Bit 0 is the rightmost digit.
- `cathode`, out, 7: active-low segments, order {g,f,e,d,c,b,a}.
- `frame_tick`, out, 1: one-cycle pulse when a new frame starts at digit 0.
- `pending`, out, 1: a captured value is waiting for the next frame boundary.

## Operation
- Counters:
  - `slot_cnt` runs 0..DIGIT_CYCLES-1 and wraps.
  - `digit_idx` runs 0..3 and advances when `slot_cnt` wraps; 3 wraps to 0.
- Digit mapping, from the active register {left, right}:
  - idx0 = right[3:0]
  - idx1 = right[7:4]
  - idx2 = left[3:0]
  - idx3 = left[7:4]
- Anode enable: `anode[digit_idx]` = 0 only when `slot_cnt` ≥ BLANK_CYCLES and `disp_en`=1. All other anode bits are 1.
- Cathode: shows the hex glyph of the selected nibble whenever the anode is on. Otherwise it is 7'h7F.
- Glyphs:
  - 0 → 1000000
  - 1 → 1111001
  - 3 → 0110000
  - 5 → 0010010
  - 8 → 0000000
  - A → 0001000
  - b → 0000011
  - C → 1000110
  - d → 0100001
  - E → 0000110
  - F → 0001110
  - Remaining digits use the standard patterns.
- Capture: `load_valid`=1 writes both bytes to the shadow register and sets `pending`. A later strobe before the boundary overwrites the shadow; last write wins.
- Frame boundary is the cycle where `digit_idx`=3 and `slot_cnt`=DIGIT_CYCLES-1. On that cycle:
  - If `load_valid`=1, the incoming bytes go directly to the active register and `pending` clears.
  - Else if `pending`=1, active is loaded from shadow and `pending` clears.
  - Otherwise active is unchanged.
- The active register changes only at frame boundaries.
- `disp_en` takes effect on the next output update and does not disturb the counters or the registers.

## Timing
- Reset values (while `reset`=0 and immediately after release):
  - `anode`=4'hF, `cathode`=7'h7F
  - `frame_tick`=0, `pending`=0
  - counters=0
  - active and shadow registers = 16'h0000
- `anode`, `cathode` and `frame_tick` are registered. They reflect the counter and active state of the previous cycle, a fixed 1-cycle latency.
- First lit output after reset release: cycle BLANK_CYCLES+1 shows digit 0 with glyph "0".
- `frame_tick` is high in the cycle after each boundary cycle, i.e. the first cycle of the digit-0 blank. It is never high during reset.
- Worst-case latency from `load_valid` to display is 4·DIGIT_CYCLES+1 cycles. The best case, a strobe on the boundary cycle, is 1 cycle to the active register.
- `pending` rises the cycle after the strobe. It falls the cycle after the boundary.
- Reset asserted mid-frame: all state returns to reset values asynchronously and the shadow contents are discarded.

## Structure
- Shared package `disp_pkg`:
  - 16-entry segment glyph constant array
  - `ANODE_OFF` = 4'hF
  - `SEG_OFF` = 7'h7F
  - digit-index typedef (2 bits)
- Sub-module `hex_to_seg7`: combinational 4-bit nibble to 7-bit active-low pattern. It is instantiated once, after the nibble mux.
- Top level: counters, shadow and active registers, boundary logic, output registers.

## Test plan
All scenarios use DIGIT_CYCLES=4 and BLANK_CYCLES=1.

1. **Reset then run.** Hold `reset` low 3 cycles, then release with `disp_en`=1.
   - Outputs are F/7F during reset.
   - From cycle 2, anodes go 1110, 1101, 1011, 0111 with cathode 1000000 in each lit slot.
   - `frame_tick` pulses every 16 cycles.
2. **Single load.** Strobe left=0xA5, right=0x3C mid-frame.
   - `pending`=1 until the boundary.
   - The next frame shows C, 3, 5, A on anodes 1110, 1101, 1011, 0111.
   - Cathodes are 1000110, 0110000, 0010010, 0001000.
3. **Two loads in one frame.** Strobe 0x11/0x22, then 0xFE/0xDC, within the same frame.
   - The next frame shows only C, d, E, F.
   - No frame ever mixes the two values.
4. **Load on the boundary cycle.** Strobe 0x80/0x08 on the boundary cycle.
   - `pending` stays 0.
   - The immediately following digit 0 shows 8.
5. **Display disable.** Drive `disp_en`=0 for 20 cycles.
   - `anode`=F and `cathode`=7F throughout.
   - `frame_tick` continues every 16 cycles.
   - Re-enable resumes at the correct digit phase.
6. **Reset mid-operation.** Assert `reset` mid-frame with `pending`=1.
   - All outputs return to reset values immediately.
   - After release, the display shows 0000 and the shadow value never appears.
